// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID pipeline register for the five-stage MIPS core.
// Computes the next PC, registers the fetched word, decodes fields and keeps the fetch/stall/flush counters.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             pcsrcD,
  input  logic             jumpD,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pcF,
  output logic [31:0]      instrD,
  output logic [31:0]      pcplus4D,
  output logic             validD,
  output logic [5:0]       opD,
  output logic [5:0]       funcD,
  output logic [4:0]       rsD,
  output logic [4:0]       rtD,
  output logic [4:0]       rdD,
  output logic [31:0]      signimmD,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [15:0]      flush_count,
  input  logic [1:0]       dbg_sel,
  output logic [31:0]      disdata
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pcplus4_q, pcplus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]      flush_cnt_q, flush_cnt_d;

  logic [31:0] pcplus4F;
  logic [31:0] pcbranchD;
  logic [31:0] pcjumpD;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] fetch_lo;

  always_comb begin
    signimmD  = {{16{instr_q[15]}}, instr_q[15:0]};
    pcplus4F  = pc_q + 32'd4;
    pcbranchD = pcplus4_q + {signimmD[29:0], 2'b00};
    pcjumpD   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
    redirect  = jumpD | pcsrcD;
  end

  // Jump outranks branch when the decoder asserts both.
  always_comb begin
    pc_next = pcplus4F;
    if (jumpD)
      pc_next = pcjumpD;
    else if (pcsrcD)
      pc_next = pcbranchD;
  end

  // A redirect arriving while stallF is high is dropped; the hazard unit re-presents it.
  always_comb begin
    pc_d = pc_q;
    if (!stallF)
      pc_d = pc_next;
  end

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (!stallD) begin
      if (redirect) begin
        instr_d   = 32'h0000_0000;
        pcplus4_d = 32'h0000_0000;
        valid_d   = 1'b0;
      end else begin
        instr_d   = imem_rdata;
        pcplus4_d = pcplus4F;
        valid_d   = 1'b1;
      end
    end
  end

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!stallF && (fetch_cnt_q != {CNT_W{1'b1}}))
      fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect && !stallD && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0000_0000;
      pcplus4_q   <= 32'h0000_0000;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= 16'h0000;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcplus4_q   <= pcplus4_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  generate
    if (CNT_W >= 32) begin : g_fetch_wide
      assign fetch_lo = fetch_cnt_q[31:0];
    end else begin : g_fetch_narrow
      assign fetch_lo = {{(32-CNT_W){1'b0}}, fetch_cnt_q};
    end
  endgenerate

  always_comb begin
    unique case (dbg_sel)
      2'b00:   disdata = pc_q;
      2'b01:   disdata = instr_q;
      2'b10:   disdata = {valid_q, stallF, stallD, pcsrcD, jumpD, 11'b0, flush_cnt_q};
      default: disdata = fetch_lo;
    endcase
  end

  always_comb begin
    imem_addr   = pc_q;
    pcF         = pc_q;
    instrD      = instr_q;
    pcplus4D    = pcplus4_q;
    validD      = valid_q;
    opD         = instr_q[31:26];
    rsD         = instr_q[25:21];
    rtD         = instr_q[20:16];
    rdD         = instr_q[15:11];
    funcD       = instr_q[5:0];
    fetch_count = fetch_cnt_q;
    stall_count = stall_cnt_q;
    flush_count = flush_cnt_q;
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a default-width instance plus a 3-bit counter instance driven alike.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, pcsrcD, jumpD;
  logic [1:0]  dbg_sel;
  logic [31:0] imem_addr, imem_rdata, pcF, instrD, pcplus4D, signimmD, disdata;
  logic        validD;
  logic [5:0]  opD, funcD;
  logic [4:0]  rsD, rtD, rdD;
  logic [31:0] fetch_count, stall_count;
  logic [15:0] flush_count;

  logic [31:0] s_imem_addr, s_imem_rdata, s_pcF, s_instrD, s_pcplus4D, s_signimmD, s_disdata;
  logic        s_validD;
  logic [5:0]  s_opD, s_funcD;
  logic [4:0]  s_rsD, s_rtD, s_rdD;
  logic [2:0]  s_fetch_count, s_stall_count;
  logic [15:0] s_flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0xC: beq imm=-1; 0x14: j 0x0FFFFFFC; 0x10000000: j with instr[25:0]=0x40; else address tag.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_000C: return 32'h1000_FFFF;
      32'h0000_0014: return 32'h0BFF_FFFF;
      32'h1000_0000: return 32'h0800_0040;
      default:       return {4'hC, a[27:0]};
    endcase
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign s_imem_rdata = mem_word(s_imem_addr);

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D),
    .validD(validD), .opD(opD), .funcD(funcD), .rsD(rsD), .rtD(rtD), .rdD(rdD), .signimmD(signimmD),
    .fetch_count(fetch_count), .stall_count(stall_count), .flush_count(flush_count),
    .dbg_sel(dbg_sel), .disdata(disdata)
  );

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata), .pcF(s_pcF), .instrD(s_instrD),
    .pcplus4D(s_pcplus4D), .validD(s_validD), .opD(s_opD), .funcD(s_funcD), .rsD(s_rsD), .rtD(s_rtD),
    .rdD(s_rdD), .signimmD(s_signimmD), .fetch_count(s_fetch_count), .stall_count(s_stall_count),
    .flush_count(s_flush_count), .dbg_sel(dbg_sel), .disdata(s_disdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v);
    chk({tag, ".pcF"}, pcF, pc);
    chk({tag, ".instrD"}, instrD, ins);
    chk({tag, ".pcplus4D"}, pcplus4D, p4);
    chk({tag, ".validD"}, {31'b0, validD}, {31'b0, v});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] f, input logic [31:0] s, input logic [15:0] fl);
    chk({tag, ".fetch"}, fetch_count, f);
    chk({tag, ".stall"}, stall_count, s);
    chk({tag, ".flush"}, {16'b0, flush_count}, {16'b0, fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0; dbg_sel = 2'b00;
    #3;
    chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("rst", 32'd0, 32'd0, 16'd0);
    chk("rst.imem_addr", imem_addr, 32'h0);
    chk("rst.dis0", disdata, 32'h0);
    reset = 1'b1;

    tick();  // edge 1
    chk_ifid("e1", 32'h4, 32'hC000_0000, 32'h4, 1'b1);
    tick();  // edge 2
    chk_ifid("e2", 32'h8, 32'hC000_0004, 32'h8, 1'b1);
    chk_cnt("e2", 32'd2, 32'd0, 16'd0);

    stallF = 1'b1; stallD = 1'b1;
    tick(); tick(); tick();  // edges 3-5
    chk_ifid("stall", 32'h8, 32'hC000_0004, 32'h8, 1'b1);
    chk_cnt("stall", 32'd2, 32'd3, 16'd0);
    dbg_sel = 2'b10; #1;
    chk("stall.dis2", disdata, 32'hE000_0000);
    dbg_sel = 2'b00;
    stallF = 1'b0; stallD = 1'b0;

    tick();  // edge 6
    chk_ifid("resume", 32'hC, 32'hC000_0008, 32'hC, 1'b1);
    tick();  // edge 7
    chk_ifid("beqD", 32'h10, 32'h1000_FFFF, 32'h10, 1'b1);
    chk("beqD.signimm", signimmD, 32'hFFFF_FFFF);
    chk("beqD.op", {26'b0, opD}, 32'd4);
    chk("beqD.func", {26'b0, funcD}, 32'h3F);
    chk("beqD.rs_rt_rd", {17'b0, rsD, rtD, rdD}, {17'b0, 5'd0, 5'd0, 5'd31});

    pcsrcD = 1'b1;
    tick();  // edge 8
    chk_ifid("br", 32'hC, 32'h0, 32'h0, 1'b0);
    chk_cnt("br", 32'd5, 32'd3, 16'd1);
    chk("br.bubble_opfunc", {20'b0, opD, funcD}, 32'h0);
    pcsrcD = 1'b0;

    tick();  // edge 9
    chk_ifid("refetch", 32'h10, 32'h1000_FFFF, 32'h10, 1'b1);

    pcsrcD = 1'b1; stallF = 1'b1; stallD = 1'b1;
    tick(); tick();  // edges 10-11
    chk_ifid("brstall", 32'h10, 32'h1000_FFFF, 32'h10, 1'b1);
    chk_cnt("brstall", 32'd6, 32'd5, 16'd1);
    stallF = 1'b0; stallD = 1'b0;
    tick();  // edge 12
    chk_ifid("brafter", 32'hC, 32'h0, 32'h0, 1'b0);
    chk_cnt("brafter", 32'd7, 32'd5, 16'd2);
    pcsrcD = 1'b0;

    tick(); tick(); tick();  // edges 13-15
    chk_ifid("jD", 32'h18, 32'h0BFF_FFFF, 32'h18, 1'b1);
    jumpD = 1'b1;
    tick();  // edge 16
    chk_ifid("j", 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b0);
    jumpD = 1'b0;
    tick();  // edge 17
    chk_ifid("wrap", 32'h1000_0000, 32'hCFFF_FFFC, 32'h1000_0000, 1'b1);
    tick();  // edge 18
    chk_ifid("j2D", 32'h1000_0004, 32'h0800_0040, 32'h1000_0004, 1'b1);
    dbg_sel = 2'b01; #1;
    chk("j2D.dis1", disdata, 32'h0800_0040);

    jumpD = 1'b1; pcsrcD = 1'b1;
    tick();  // edge 19
    chk_ifid("jwins", 32'h1000_0100, 32'h0, 32'h0, 1'b0);
    chk_cnt("jwins", 32'd14, 32'd5, 16'd4);
    jumpD = 1'b0; pcsrcD = 1'b0;
    dbg_sel = 2'b11; #1;
    chk("dis3", disdata, 32'd14);
    chk("small.dis3_sat", s_disdata, 32'd7);
    chk("small.fetch_sat", {29'b0, s_fetch_count}, 32'd7);
    chk("small.stall", {29'b0, s_stall_count}, 32'd5);
    dbg_sel = 2'b10; #1;
    chk("dis2", disdata, 32'h0000_0004);
    dbg_sel = 2'b00; #1;
    chk("dis0", disdata, 32'h1000_0100);

    tick();  // edge 20
    chk_ifid("e20", 32'h1000_0104, 32'hC000_0100, 32'h1000_0104, 1'b1);
    stallF = 1'b1; stallD = 1'b1; pcsrcD = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_ifid("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("midrst", 32'd0, 32'd0, 16'd0);
    chk("midrst.small_fetch", {29'b0, s_fetch_count}, 32'd0);
    #1 reset = 1'b1;
    stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0;
    tick();
    chk_ifid("restart", 32'h4, 32'hC000_0000, 32'h4, 1'b1);
    chk_cnt("restart", 32'd1, 32'd0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Instruction-fetch stage plus IF/ID pipeline register for the five-stage pipelined MIPS core. Holds the PC, drives the instruction-memory address, and computes the next PC from sequential, branch and jump sources. It registers the fetched word into the decode stage and splits it into the fields consumed by the control unit and register file. Stall and flush inputs come from the hazard unit. Small performance counters and a debug display mux feed the board's seven-segment path.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of fetch_count and stall_count (flush_count fixed 16)
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- stallF  in  1  hold PC
- stallD  in  1  hold IF/ID register
- pcsrcD  in  1  taken branch resolved in D
- jumpD  in  1  j instruction in D
- imem_addr  out  32  instruction-memory byte address (= pcF)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- pcF  out  32  current fetch PC
- instrD  out  32  registered instruction in decode
- pcplus4D  out  32  registered pcF+4 of that instruction
- validD  out  1  instrD holds a real fetched instruction (0 = bubble)
- opD, funcD  out  6 each  instrD[31:26], instrD[5:0]
- rsD, rtD, rdD  out  5 each  instrD[25:21], [20:16], [15:11]
- signimmD  out  32  sign-extended instrD[15:0]
- fetch_count  out  CNT_W  cycles in which PC advanced
- stall_count  out  CNT_W  cycles with stallF=1
- flush_count  out  16  IF/ID flushes applied
- dbg_sel  in  2  debug display select
- disdata  out  32  debug display word

## Operation
- pcplus4F = pcF+4; pcbranchD = pcplus4D + (signimmD<<2); pcjumpD = {pcplus4D[31:28], instrD[25:0], 2'b00}. All arithmetic mod 2^32, carries dropped.
- redirect = jumpD | pcsrcD. Next PC priority: jumpD -> pcjumpD; else pcsrcD -> pcbranchD; else pcplus4F.
- PC register: stallF=1 holds pcF, and any redirect that cycle is discarded. The hazard unit re-presents it after the stall. Otherwise pcF <= next PC.
- IF/ID register, priority stallD > flush > load:
  - stallD=1: hold instrD, pcplus4D and validD.
  - else redirect=1: instrD <= 0 (nop), pcplus4D <= 0, validD <= 0.
  - else: instrD <= imem_rdata, pcplus4D <= pcplus4F, validD <= 1.
- Decode fields are pure combinational slices of instrD. A bubble therefore decodes as sll $0 (op=0, func=0).
- Counters:
  - fetch_count +1 when stallF=0.
  - stall_count +1 when stallF=1.
  - flush_count +1 when redirect=1 and stallD=0.
  - All counters saturate at all-ones and do not wrap.
- disdata mux, combinational:
  - 00: pcF.
  - 01: instrD.
  - 10: {validD, stallF, stallD, pcsrcD, jumpD, 11'b0, flush_count}.
  - 11: fetch_count low 32 bits, zero-extended if CNT_W<32.

## Timing
- Reset (reset=0, asynchronous): pcF=RESET_PC, instrD=0, pcplus4D=0, validD=0, all counters 0. First edge after reset releases fetches RESET_PC.
- Word fetched at pcF in cycle n appears on instrD/validD after edge n+1. Fetch-to-decode latency is 1 cycle.
- Redirect visible in D during cycle n: pcF = target after edge n+1, and the wrong-path word fetched in cycle n becomes a bubble. Branch penalty is 1 cycle.
- stallF and stallD are normally asserted together. If stallD=1 and stallF=0, the word fetched that cycle is lost. This is legal; the hazard unit never requests it.
- Reset asserted mid-operation overrides everything in the same instant, including pending redirects and stalls.

## Test plan
- Reset then 4 free-running cycles, imem returns addr-tagged words: pcF 0,4,8,12. instrD lags one cycle. validD 0 in the first cycle, then 1. fetch_count=4.
- stallF=stallD=1 for 3 cycles at pcF=8: pcF stays 8, instrD frozen, stall_count=3, fetch_count unchanged. Sequence resumes at 12.
- Branch in D: pcplus4D=0x10, imm=0xFFFF, pcsrcD=1. Next pcF=0x0C, next validD=0, next instrD=0, flush_count=1.
- jumpD=1 and pcsrcD=1 together, instrD[25:0]=0x40, pcplus4D=0x1000_0004. Next pcF=0x1000_0100 (jump wins).
- Redirect with stallF=stallD=1: pcF and IF/ID hold, flush_count unchanged. Redirect is taken on the first cycle the stalls drop.
- reset pulsed low mid-stream between edges: outputs go to reset values immediately, with no clock edge needed. Run resumes at RESET_PC.
